// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential, valid/ready-handshaked ALU. Single-cycle ADD,
//                SUB, SLT, AND, OR and NOR, plus iterative (one bit per
//                cycle) unsigned MUL and, when ALU_SEQ_DIV_EN is defined,
//                DIVU/REMU. All results and flags are registered.
//  Config      : ALU_SEQ_DIV_EN - include the restoring divider. When it is
//                undefined, op codes 1010/1011 behave as illegal fast ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_LEN-1:0] A,
    input  logic [WORD_LEN-1:0] B,
    input  logic [3:0]          op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_LEN-1:0] res,
    output logic                zero,
    output logic                overflow,
    output logic                busy
);

    localparam int CNT_W = $clog2(WORD_LEN + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic                  accept;
    logic                  start_iter;
    logic                  last_iter;
    logic [CNT_W-1:0]      cnt;
    logic [WORD_LEN-1:0]   res_reg;
    logic                  ovf_reg;

    // Fast-op datapath
    logic [WORD_LEN-1:0]   sum_add;
    logic [WORD_LEN-1:0]   sum_sub;
    logic                  add_ovf;
    logic                  sub_ovf;
    logic [WORD_LEN-1:0]   fast_res;
    logic                  fast_ovf;

    // Shift-add multiplier: upper half accumulates, lower half holds the
    // not-yet-consumed multiplier bits.
    logic [WORD_LEN-1:0]   a_reg;
    logic [2*WORD_LEN-1:0] acc;
    logic [WORD_LEN:0]     mul_add;
    logic [2*WORD_LEN-1:0] acc_next;

    // Iteration result written on the final BUSY cycle
    logic [WORD_LEN-1:0]   iter_res;
    logic                  iter_ovf;

`ifdef ALU_SEQ_DIV_EN
    // Restoring divider: quot starts as the dividend and shifts quotient
    // bits in from the right while the dividend bits shift out the top.
    logic [WORD_LEN-1:0]   b_reg;
    logic [3:0]            op_reg;
    logic [WORD_LEN:0]     rem;
    logic [WORD_LEN-1:0]   quot;
    logic [WORD_LEN+1:0]   trial;
    logic [WORD_LEN:0]     rem_next;
    logic [WORD_LEN-1:0]   quot_next;
`endif

    assign accept    = in_valid & in_ready;
    assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_BUSY);
    assign last_iter = (cnt == CNT_W'(WORD_LEN - 1));
    assign res       = res_reg;
    assign overflow  = ovf_reg;
    assign zero      = ~|res_reg;

    // Decide whether the op on the inputs needs the iterative path
    always_comb begin
        start_iter = (op == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
        if (((op == OP_DIVU) || (op == OP_REMU)) && (B != '0)) begin
            start_iter = 1'b1;
        end
`endif
    end

    // Single-cycle results, including divide-by-zero short cuts
    always_comb begin
        sum_add  = A + B;
        sum_sub  = A + ~B + 1'b1;
        add_ovf  = (A[WORD_LEN-1] == B[WORD_LEN-1]) && (sum_add[WORD_LEN-1] != A[WORD_LEN-1]);
        sub_ovf  = (A[WORD_LEN-1] != B[WORD_LEN-1]) && (sum_sub[WORD_LEN-1] != A[WORD_LEN-1]);
        fast_res = '0;
        fast_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                fast_res = sum_add;
                fast_ovf = add_ovf;
            end
            OP_SUB: begin
                fast_res = sum_sub;
                fast_ovf = sub_ovf;
            end
            OP_SLT: begin
                // N xor V gives the true signed less-than even on overflow
                fast_res = {{(WORD_LEN-1){1'b0}}, sum_sub[WORD_LEN-1] ^ sub_ovf};
                fast_ovf = sub_ovf;
            end
            OP_OR:  fast_res = A | B;
            OP_AND: fast_res = A & B;
            OP_NOR: fast_res = ~(A | B);
`ifdef ALU_SEQ_DIV_EN
            // Only reaches the result register when B is zero
            OP_DIVU: begin
                fast_res = '1;
                fast_ovf = 1'b1;
            end
            OP_REMU: begin
                fast_res = A;
                fast_ovf = 1'b1;
            end
`endif
            default: begin
                fast_res = '0;
                fast_ovf = 1'b0;
            end
        endcase
    end

    // One iteration step of the multiplier (and divider when present)
    always_comb begin
        mul_add  = {1'b0, acc[2*WORD_LEN-1:WORD_LEN]} + (acc[0] ? {1'b0, a_reg} : '0);
        acc_next = {mul_add, acc[WORD_LEN-1:1]};
`ifdef ALU_SEQ_DIV_EN
        trial     = {rem, quot[WORD_LEN-1]} - {2'b00, b_reg};
        rem_next  = trial[WORD_LEN+1] ? {rem[WORD_LEN-1:0], quot[WORD_LEN-1]} : trial[WORD_LEN:0];
        quot_next = {quot[WORD_LEN-2:0], ~trial[WORD_LEN+1]};
        if (op_reg == OP_MUL) begin
            iter_res = acc_next[WORD_LEN-1:0];
            iter_ovf = |acc_next[2*WORD_LEN-1:WORD_LEN];
        end else if (op_reg == OP_DIVU) begin
            iter_res = quot_next;
            iter_ovf = 1'b0;
        end else begin
            iter_res = rem_next[WORD_LEN-1:0];
            iter_ovf = 1'b0;
        end
`else
        iter_res = acc_next[WORD_LEN-1:0];
        iter_ovf = |acc_next[2*WORD_LEN-1:WORD_LEN];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = start_iter ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_next = start_iter ? S_BUSY : S_DONE;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_reg   <= '0;
            acc     <= '0;
            res_reg <= '0;
            ovf_reg <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            b_reg   <= '0;
            op_reg  <= '0;
            rem     <= '0;
            quot    <= '0;
`endif
        end else if (accept) begin
            cnt   <= '0;
            a_reg <= A;
            acc   <= {{WORD_LEN{1'b0}}, B};
`ifdef ALU_SEQ_DIV_EN
            b_reg  <= B;
            op_reg <= op;
            rem    <= '0;
            quot   <= A;
`endif
            if (!start_iter) begin
                res_reg <= fast_res;
                ovf_reg <= fast_ovf;
            end
        end else if (state == S_BUSY) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_next;
`ifdef ALU_SEQ_DIV_EN
            rem  <= rem_next;
            quot <= quot_next;
`endif
            if (last_iter) begin
                res_reg <= iter_res;
                ovf_reg <= iter_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq (WORD_LEN=32). Expected
//                results are queued when an op is driven and compared when
//                the result is handed off; scenario tasks add inline checks
//                for latency, flags and handshake behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         zero;
    logic         overflow;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // {overflow, res}
    logic [W:0] sb[$];

    alu_seq #(.WORD_LEN(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .zero      (zero),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model built on wide signed/unsigned arithmetic
    function automatic logic [W:0] model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       s;
        logic [63:0]  p;
        logic [W-1:0] r;
        logic         v;
        r = '0;
        v = 1'b0;
        case (o)
            OP_ADD: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB, OP_SLT: begin
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                if (o == OP_SUB) r = a - b;
                else             r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
            OP_OR:  r = a | b;
            OP_AND: r = a & b;
            OP_NOR: r = ~(a | b);
            OP_MUL: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
                v = (p[63:32] != 32'd0);
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; v = 1'b1; end
                else        r = a / b;
            end
            OP_REMU: begin
                if (b == 0) begin r = a; v = 1'b1; end
                else        r = a % b;
            end
`endif
            default: begin
                r = '0;
                v = 1'b0;
            end
        endcase
        return {v, r};
    endfunction

    function automatic int exp_latency(input logic [3:0] o, input logic [W-1:0] b);
        if (o == OP_MUL) return W + 1;
`ifdef ALU_SEQ_DIV_EN
        if ((o == OP_DIVU || o == OP_REMU) && b != 0) return W + 1;
`endif
        return 1;
    endfunction

    // Scoreboard consumer: compares every handed-off result in order
    initial begin : monitor
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got res=%h ovf=%b, required no result", res, overflow);
                end else begin
                    e = sb.pop_front();
                    if ({overflow, zero, res} !== {e[W], (e[W-1:0] == 0), e[W-1:0]}) begin
                        errors++;
                        $display("FAIL sb_result: got res=%h zero=%b ovf=%b, required res=%h zero=%b ovf=%b",
                                 res, zero, overflow, e[W-1:0], (e[W-1:0] == 0), e[W]);
                    end
                end
            end
        end
    end

    // Issue one op, wait for its result and return what was observed
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int nbusy,
                          output logic [W-1:0] r, output logic z, output logic v);
        int guard;
        op = o; A = a; B = b; in_valid = 1'b1;
        sb.push_back(model(o, a, b));
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = '1; B = '1; op = OP_ADD;
        lat   = 1;
        nbusy = busy ? 1 : 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) nbusy++;
        end
        r = res; z = zero; v = overflow;
        checks++;
        if (lat !== exp_latency(o, b)) begin
            errors++;
            $display("FAIL latency op=%b: got %0d, required %0d", o, lat, exp_latency(o, b));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; op = OP_AND;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, res, zero, overflow, busy, in_ready} !== {1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got ov=%b res=%h z=%b ovf=%b busy=%b ir=%b, required 0 0 1 0 0 1",
                     out_valid, res, zero, overflow, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_release: got ov=%b busy=%b ir=%b, required 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_add();
        int lat, nb; logic [W-1:0] r; logic z, v;
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, lat, nb, r, z, v);
        checks++;
        if ({r, z, v} !== {32'h8000_0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got res=%h z=%b ovf=%b, required 80000000 0 1", r, z, v);
        end
    endtask

    task automatic test_sub_slt();
        int lat, nb; logic [W-1:0] r; logic z, v;
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat, nb, r, z, v);
        checks++;
        if (r !== 32'd1) begin errors++; $display("FAIL slt_neg1: got %h, required 1", r); end
        run_op(OP_SLT, 32'h8000_0000, 32'd1, lat, nb, r, z, v);
        checks++;
        if ({r, v} !== {32'd1, 1'b1}) begin errors++; $display("FAIL slt_ovf: got res=%h ovf=%b, required 1 1", r, v); end
        run_op(OP_SUB, 32'h8000_0000, 32'd1, lat, nb, r, z, v);
        checks++;
        if ({r, v} !== {32'h7FFF_FFFF, 1'b1}) begin errors++; $display("FAIL sub_ovf: got res=%h ovf=%b, required 7fffffff 1", r, v); end
        run_op(OP_SLT, 32'd1, 32'hFFFF_FFFF, lat, nb, r, z, v);
        checks++;
        if ({r, z} !== {32'd0, 1'b1}) begin errors++; $display("FAIL slt_false: got res=%h z=%b, required 0 1", r, z); end
    endtask

    task automatic test_logic();
        int lat, nb; logic [W-1:0] r; logic z, v;
        logic [3:0] ops [4] = '{OP_OR, OP_AND, OP_NOR, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 32'hF0F0_1234, 32'h0FF0_4321, lat, nb, r, z, v);
        end
    endtask

    task automatic test_mul();
        int lat, nb; logic [W-1:0] r; logic z, v;
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, lat, nb, r, z, v);
        checks++;
        if ({r, z, v} !== {32'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mul_wrap: got res=%h z=%b ovf=%b, required 0 1 1", r, z, v);
        end
        checks++;
        if (nb !== W) begin errors++; $display("FAIL mul_busy: got %0d busy cycles, required %0d", nb, W); end
        run_op(OP_MUL, 32'd7, 32'd6, lat, nb, r, z, v);
        checks++;
        if ({r, v} !== {32'd42, 1'b0}) begin errors++; $display("FAIL mul_small: got res=%h ovf=%b, required 2a 0", r, v); end
        run_op(OP_MUL, 32'hDEAD_BEEF, 32'h1234_5679, lat, nb, r, z, v);
    endtask

    task automatic test_div();
        int lat, nb; logic [W-1:0] r; logic z, v;
`ifdef ALU_SEQ_DIV_EN
        run_op(OP_DIVU, 32'd100, 32'd7, lat, nb, r, z, v);
        checks++;
        if (r !== 32'd14) begin errors++; $display("FAIL divu: got %0d, required 14", r); end
        run_op(OP_REMU, 32'd100, 32'd7, lat, nb, r, z, v);
        checks++;
        if (r !== 32'd2) begin errors++; $display("FAIL remu: got %0d, required 2", r); end
        run_op(OP_DIVU, 32'd5, 32'd0, lat, nb, r, z, v);
        checks++;
        if ({r, v} !== {32'hFFFF_FFFF, 1'b1}) begin errors++; $display("FAIL divu_zero: got res=%h ovf=%b, required ffffffff 1", r, v); end
        run_op(OP_REMU, 32'd5, 32'd0, lat, nb, r, z, v);
        checks++;
        if ({r, v} !== {32'd5, 1'b1}) begin errors++; $display("FAIL remu_zero: got res=%h ovf=%b, required 5 1", r, v); end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd3, lat, nb, r, z, v);
        run_op(OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, lat, nb, r, z, v);
`else
        run_op(OP_DIVU, 32'd100, 32'd7, lat, nb, r, z, v);
        checks++;
        if ({r, v} !== {32'd0, 1'b0}) begin errors++; $display("FAIL divu_disabled: got res=%h ovf=%b, required 0 0", r, v); end
`endif
    endtask

    // Leaves the DUT in DONE with a stalled result and the next op held
    task automatic test_backpressure();
        out_ready = 1'b0;
        op = OP_ADD; A = 32'd10; B = 32'd20; in_valid = 1'b1;
        sb.push_back(model(OP_ADD, 32'd10, 32'd20));
        @(posedge clk); #1;
        op = OP_ADD; A = 32'd100; B = 32'd1;
        sb.push_back(model(OP_ADD, 32'd100, 32'd1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, res, overflow} !== {1'b1, 1'b0, 32'd30, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_hold: got ov=%b ir=%b res=%h ovf=%b, required 1 0 1e 0",
                         out_valid, in_ready, res, overflow);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sa [4] = '{32'd100, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
        logic [W-1:0] sbv[4] = '{32'd1, 32'd1, 32'h8000_0000, 32'd6};
        logic [W:0]   e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            e = model(OP_ADD, sa[i], sbv[i]);
            checks++;
            if ({out_valid, overflow, res} !== {1'b1, e}) begin
                errors++;
                $display("FAIL stream_%0d: got ov=%b ovf=%b res=%h, required 1 %b %h",
                         i, out_valid, overflow, res, e[W], e[W-1:0]);
            end
            if (i < 3) begin
                A = sa[i+1]; B = sbv[i+1];
                sb.push_back(model(OP_ADD, sa[i+1], sbv[i+1]));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got out_valid=%b, required 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int lat, nb; logic [W-1:0] r; logic z, v;
        op = OP_MUL; A = 32'h0012_3456; B = 32'h0000_0777; in_valid = 1'b1;
        sb.push_back(model(OP_MUL, 32'h0012_3456, 32'h0000_0777));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy: got busy=%b, required 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, res, zero, busy, overflow} !== {1'b0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_mul_reset: got ov=%b res=%h z=%b busy=%b ovf=%b, required 0 0 1 0 0",
                     out_valid, res, zero, busy, overflow);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(OP_ADD, 32'd2, 32'd3, lat, nb, r, z, v);
        checks++;
        if (r !== 32'd5) begin errors++; $display("FAIL post_reset_add: got %h, required 5", r); end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        test_reset();
        test_add();
        test_sub_slt();
        test_logic();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending results, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Sequential, handshaked successor to the combinational datapath ALU. Adds iterative unsigned multiply and divide/remainder to the existing single-cycle operations, parametrised in word width, and registers every result behind a valid/ready interface. Sits between the decode/issue stage and write-back; the issuer stalls on `in_ready`, and write-back consumes results on `out_valid`/`out_ready`.

## Interface
- `WORD_LEN`, 32: operand/result width; legal range is ≥4.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands and op are valid.
- `in_ready` output 1: block accepts an operation this cycle.
- `A` input WORD_LEN: operand A.
- `B` input WORD_LEN: operand B.
- `op` input 4: operation code.
- `out_valid` output 1: `res`/flags are valid.
- `out_ready` input 1: consumer accepts the result.
- `res` output WORD_LEN: registered result.
- `zero` output 1: `~|res`.
- `overflow` output 1: registered overflow flag.
- `busy` output 1: high while in the iterative state.

## Operation
- Op codes:
  - 0010 ADD.
  - 0110 SUB (A + ~B + 1).
  - 0111 SLT, signed: `res = {0…, N^V}` of A−B. This corrects the sign-bit-only compare.
  - 0001 OR.
  - 0000 AND.
  - 1100 NOR.
  - 1000 MUL: low WORD_LEN bits of the unsigned product.
  - 1010 DIVU: unsigned quotient.
  - 1011 REMU: unsigned remainder.
  - Any other code: `res=0`, `overflow=0`, completes as a fast op.
- `overflow` rules:
  - ADD/SUB/SLT: signed overflow, i.e. operand signs equal (after B inversion for SUB/SLT) and the result sign differs.
  - MUL: 1 iff the unsigned product's high WORD_LEN bits are nonzero.
  - DIVU/REMU: 1 only on divide-by-zero.
  - Logic ops: 0.
- States:
  - IDLE: `in_ready=1`. On accept of a fast op, or of DIVU/REMU with B==0, go to DONE. On accept of MUL/DIVU/REMU with B≠0, go to BUSY.
  - BUSY: iterate one bit per cycle; counter width `$clog2(WORD_LEN+1)`.
    - MUL: shift-add into a 2·WORD_LEN accumulator.
    - DIVU/REMU: restoring division on a WORD_LEN+1-bit partial remainder.
    - After WORD_LEN iterations, go to DONE. `in_ready=0`.
  - DONE: `out_valid=1`; `res` and flags are stable. On `out_ready`, either accept a new op in the same cycle (`in_ready = out_ready`) and follow the IDLE rules, or go to IDLE if `in_valid=0`.
- Divide-by-zero: quotient = all ones; remainder = A; `overflow=1`.
- Operands are captured at accept. Later changes on `A`, `B` or `op` have no effect on the operation in flight.
- `in_valid` while `in_ready=0` is ignored; the issuer holds it.
- Reset, any state, including mid-iteration:
  - State returns to IDLE and the iteration is discarded.
  - `out_valid=0`, `res=0`, `zero=1`, `overflow=0`, `busy=0`, `in_ready=1` after reset release.

## Timing
- Fast ops: accepted at edge N; `out_valid` high after edge N+1 (latency 1).
- MUL/DIVU/REMU, B≠0: `busy` high for WORD_LEN cycles; `out_valid` high WORD_LEN+1 cycles after accept.
- Back-to-back fast ops with `out_ready` held high sustain 1 op/cycle.
- Backpressure: `res`, `zero`, `overflow` hold unchanged while `out_valid && !out_ready`.
- `zero` is combinational from the `res` register; it adds no extra cycle.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIVU/REMU implemented as above.
- Not defined:
  - The divider datapath is removed.
  - 1010/1011 are treated as illegal codes: fast op, `res=0`, `overflow=0`, latency 1.
  - MUL is unaffected.

## Test plan
- ADD, WORD_LEN=32: A=0x7FFFFFFF, B=1 -> `res=0x80000000`, `overflow=1`, `zero=0`, `out_valid` 1 cycle after accept.
- SLT and SUB: A=0xFFFFFFFF, B=1 -> `res=1`. A=0x80000000, B=1 -> SLT `res=1`; SUB gives `res=0x7FFFFFFF` with `overflow=1`.
- MUL: A=0x00010000, B=0x00010000 -> `res=0`, `zero=1`, `overflow=1`, `busy` high 32 cycles, `out_valid` at cycle 33. A=7, B=6 -> `res=42`, `overflow=0`.
- Division, `ALU_SEQ_DIV_EN` defined:
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - DIVU 5/0 -> `res=0xFFFFFFFF`, `overflow=1`, latency 1.
  - REMU 5/0 -> `res=5`.
  - With the macro undefined: DIVU 100/7 -> `res=0`, latency 1.
- Backpressure and throughput: hold `out_ready=0` 5 cycles after a result -> `res` is stable and `in_ready=0`. Then stream 4 ADDs with `out_ready=1` -> 4 results on 4 consecutive cycles, in order.
- Reset mid-MUL: assert `rst_n=0` at iteration 10 -> immediately `out_valid=0`, `res=0`, `zero=1`, `busy=0`. After release, ADD 2+3 -> `res=5`.
